// File: rtl/alu_issue_ctrl_if.sv
// Request, response and ALU operand/result bundle for alu_issue_ctrl.
// slave = the issue controller; master = producer, consumer and ALU around it.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 5,
    parameter int OP_W   = 2
);
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // A valid source holds its payload steady until that edge; ready may change freely.
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_f;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_f;
    logic [OP_W-1:0]   rsp_op;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_f,
        output req_ready, rsp_valid, rsp_f, rsp_op, alu_a, alu_b, alu_op
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_f,
        input  req_ready, rsp_valid, rsp_f, rsp_op, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the registered ALU: request FIFO, held operand lines, result capture.
// Optional macro ALU_ISSUE_STATS_EN adds a saturating done_cnt of response handshakes.
module alu_issue_ctrl #(
    parameter int DATA_W  = 5,
    parameter int OP_W    = 2,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    alu_issue_ctrl_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic [1:0]                 state_dbg
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [7:0]                 done_cnt
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LAT_W = $clog2(ALU_LAT + 1);
    localparam int ENT_W = OP_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LAT_W-1:0] wait_cnt;
    logic [ENT_W-1:0] head;
    logic             full;
    logic             push;
    logic             issue;

    assign full          = (count == CNT_W'(DEPTH));
    assign bus.req_ready = !full;
    assign push          = bus.req_valid && !full;
    // Pop only from registered occupancy, so a fresh request never bypasses the FIFO.
    assign issue         = (count != '0) &&
                           ((state == IDLE) || (state == RESP && bus.rsp_ready));
    assign head          = mem[rd_ptr];
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.req_op, bus.req_a, bus.req_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            wait_cnt      <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_f     <= '0;
            bus.rsp_op    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        {bus.alu_op, bus.alu_a, bus.alu_b} <= head;
                        wait_cnt <= LAT_W'(ALU_LAT);
                        state    <= WAIT;
                        busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        bus.rsp_f     <= bus.alu_f;
                        bus.rsp_op    <= bus.alu_op;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        // Back-to-back: the next queued op issues on the handshake edge.
                        if (issue) begin
                            {bus.alu_op, bus.alu_a, bus.alu_b} <= head;
                            wait_cnt <= LAT_W'(ALU_LAT);
                            state    <= WAIT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready && done_cnt != 8'hFF) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table, hand-written corner sequences and a random
// phase scored against an in-order expected queue built from a reference ALU function.
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] count;
    logic       busy;
    logic [1:0] state_dbg;
`ifdef ALU_ISSUE_STATS_EN
    logic [7:0] done_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_hs  = 0;

    logic [6:0] exp_q[$];

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [1:0] op;
        logic [4:0] exp_f;
    } vec_t;

    vec_t vecs[7];

    alu_issue_ctrl_if #(.DATA_W(5), .OP_W(2)) bus ();

    alu_issue_ctrl #(
        .DATA_W(5), .OP_W(2), .DEPTH(4), .ALU_LAT(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .count     (count),
        .busy      (busy),
        .state_dbg (state_dbg)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .done_cnt  (done_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference ALU ----------------
    function automatic logic [4:0] alu_ref(input logic [4:0] a, input logic [4:0] b,
                                           input logic [1:0] op);
        logic [4:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // Registered ALU with one edge of latency, as seen by the controller.
    always @(posedge clk) begin
        bus.alu_f <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every response handshake must match the oldest accepted request.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            n_cmp++;
            n_hs++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got op=%0d f=%0d expected none",
                         bus.rsp_op, bus.rsp_f);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if ({bus.rsp_op, bus.rsp_f} !== e) begin
                    n_err++;
                    $display("FAIL rsp_order: got op=%0d f=%0d expected op=%0d f=%0d",
                             bus.rsp_op, bus.rsp_f, e[6:5], e[4:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [4:0] a, input logic [4:0] b, input logic [1:0] op);
        int   guard;
        logic rdy;
        guard = 0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        do begin
            rdy = bus.req_ready;
            tick();
            guard++;
        end while (!rdy && guard < 300);
        bus.req_valid = 1'b0;
        check("push_accept", 32'(rdy), 32'd1);
        if (rdy) exp_q.push_back({op, alu_ref(a, b, op)});
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        bus.rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && guard < 500) begin
            tick();
            guard++;
        end
        check({name, "_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_count"}, 32'(count), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_count"}, 32'(count), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({name, "_rsp_f"}, 32'(bus.rsp_f), 32'd0);
        check({name, "_rsp_op"}, 32'(bus.rsp_op), 32'd0);
        check({name, "_alu_a"}, 32'(bus.alu_a), 32'd0);
        check({name, "_alu_b"}, 32'(bus.alu_b), 32'd0);
        check({name, "_alu_op"}, 32'(bus.alu_op), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic       prod_done;
        logic [4:0] f_first;
        int         cyc;

        vecs[0] = '{a: 5'd22, b: 5'd12, op: 2'b00, exp_f: 5'd2};
        vecs[1] = '{a: 5'd18, b: 5'd15, op: 2'b01, exp_f: 5'd3};
        vecs[2] = '{a: 5'd12, b: 5'd14, op: 2'b10, exp_f: 5'd12};
        vecs[3] = '{a: 5'd12, b: 5'd20, op: 2'b11, exp_f: 5'd24};
        vecs[4] = '{a: 5'd1,  b: 5'd1,  op: 2'b00, exp_f: 5'd2};
        vecs[5] = '{a: 5'd31, b: 5'd1,  op: 2'b00, exp_f: 5'd0};
        vecs[6] = '{a: 5'd0,  b: 5'd1,  op: 2'b01, exp_f: 5'd31};

        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Single requests: exact issue latency and result for each vector.
        bus.rsp_ready = 1'b1;
        foreach (vecs[i]) begin
            push_req(vecs[i].a, vecs[i].b, vecs[i].op);
            check("v_count_after_accept", 32'(count), 32'd1);
            check("v_no_bypass", 32'(busy), 32'd0);
            tick();
            check("v_alu_a", 32'(bus.alu_a), 32'(vecs[i].a));
            check("v_alu_b", 32'(bus.alu_b), 32'(vecs[i].b));
            check("v_alu_op", 32'(bus.alu_op), 32'(vecs[i].op));
            check("v_busy", 32'(busy), 32'd1);
            tick();
            check("v_rsp_not_early", 32'(bus.rsp_valid), 32'd0);
            tick();
            check("v_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("v_rsp_f", 32'(bus.rsp_f), 32'(vecs[i].exp_f));
            check("v_rsp_op", 32'(bus.rsp_op), 32'(vecs[i].op));
            tick();
            check("v_rsp_done", 32'(bus.rsp_valid), 32'd0);
            check("v_busy_done", 32'(busy), 32'd0);
        end

        // Backpressure: fill the FIFO behind a stalled response.
        bus.rsp_ready = 1'b0;
        push_req(5'd3, 5'd4, 2'b00);
        push_req(5'd9, 5'd2, 2'b01);
        push_req(5'd7, 5'd5, 2'b10);
        push_req(5'd6, 5'd6, 2'b11);
        push_req(5'd30, 5'd5, 2'b00);
        f_first = alu_ref(5'd3, 5'd4, 2'b00);
        check("bp_count_full", 32'(count), 32'd4);
        check("bp_req_ready_full", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_a     = 5'd17;
        bus.req_b     = 5'd16;
        bus.req_op    = 2'b00;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_stall_ready", 32'(bus.req_ready), 32'd0);
            check("bp_stall_count", 32'(count), 32'd4);
            check("bp_stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_stall_f", 32'(bus.rsp_f), 32'(f_first));
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp_after_pop_count", 32'(count), 32'd3);
        check("bp_after_pop_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        exp_q.push_back({2'b00, alu_ref(5'd17, 5'd16, 2'b00)});
        check("bp_sixth_accepted", 32'(count), 32'd4);
        drain("bp_drain");

        // Back-to-back issue: four queued ops complete every 3 cycles with no idle gap.
        bus.rsp_ready = 1'b0;
        push_req(5'd18, 5'd15, 2'b01);
        push_req(5'd12, 5'd14, 2'b10);
        push_req(5'd12, 5'd20, 2'b11);
        push_req(5'd1,  5'd1,  2'b00);
        check("b2b_first_valid", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            check("b2b_busy", 32'(busy), 32'd1);
            tick();
            cyc++;
        end
        check("b2b_cycles", 32'(cyc), 32'd10);
        check("b2b_idle_after", 32'(busy), 32'd0);

        // Asynchronous reset while an op is in WAIT with two entries queued.
        bus.rsp_ready = 1'b0;
        push_req(5'd5, 5'd6, 2'b00);
        push_req(5'd7, 5'd8, 2'b01);
        push_req(5'd9, 5'd10, 2'b10);
        check("rst_pre_count", 32'(count), 32'd2);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async_rst");
        n_hs = 0;
        tick();
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        check("post_rst_count", 32'(count), 32'd0);

        // Random traffic with random consumer backpressure.
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    push_req(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                             2'($urandom_range(0, 3)));
                    repeat ($urandom_range(0, 2)) tick();
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    bus.rsp_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain("rand_drain");
        check("rand_handshakes", 32'(n_hs), 32'd200);
`ifdef ALU_ISSUE_STATS_EN
        check("done_cnt", 32'(done_cnt), 32'd200);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
